// File: rtl/alu_mdu_seq.sv
// Sequential ALU with multi-cycle multiply/divide unit.
// Single-cycle ops finish in one cycle. MULT/DIV iterate WIDTH cycles. Results wait in DONE until out_ready.
module alu_mdu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] num1,
   input  logic [WIDTH-1:0] num2,
   input  logic [SHW-1:0]   sa,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             overflow,
   output logic             zero,
   output logic             div_by_zero
);

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_ADDU  = 5'd1;
   localparam logic [4:0] OP_SUB   = 5'd2;
   localparam logic [4:0] OP_SUBU  = 5'd3;
   localparam logic [4:0] OP_SLT   = 5'd4;
   localparam logic [4:0] OP_SLTU  = 5'd5;
   localparam logic [4:0] OP_AND   = 5'd6;
   localparam logic [4:0] OP_OR    = 5'd7;
   localparam logic [4:0] OP_XOR   = 5'd8;
   localparam logic [4:0] OP_NOR   = 5'd9;
   localparam logic [4:0] OP_SLL   = 5'd10;
   localparam logic [4:0] OP_SRL   = 5'd11;
   localparam logic [4:0] OP_SRA   = 5'd12;
   localparam logic [4:0] OP_SLLV  = 5'd13;
   localparam logic [4:0] OP_SRLV  = 5'd14;
   localparam logic [4:0] OP_SRAV  = 5'd15;
   localparam logic [4:0] OP_LUI   = 5'd16;
   localparam logic [4:0] OP_MULT  = 5'd17;
   localparam logic [4:0] OP_MULTU = 5'd18;
   localparam logic [4:0] OP_DIV   = 5'd19;
   localparam logic [4:0] OP_DIVU  = 5'd20;

   localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
   localparam logic [SHW-1:0] CNT_LAST = {SHW{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               neg_lo_q, neg_lo_d;
   logic               neg_hi_q, neg_hi_d;
   logic [WIDTH-1:0]   res_hi_q, res_hi_d;
   logic [WIDTH-1:0]   res_lo_q, res_lo_d;
   logic               ovf_q, ovf_d;
   logic               zero_q, zero_d;
   logic               dbz_q, dbz_d;
   logic               out_valid_q, out_valid_d;

   logic [WIDTH-1:0]   sum_s, diff_s, alu_res_s;
   logic               alu_ovf_s, alu_zero_s;
   logic [SHW-1:0]     vamt_s;

   logic               signed_op_s, neg1_s, neg2_s;
   logic [WIDTH-1:0]   abs1_s, abs2_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH-1:0]   mul_hi_s, mul_lo_s;
   logic [2*WIDTH-1:0] prod_s, prod_fix_s;
   logic [WIDTH:0]     div_shift_s, div_trial_s;
   logic [WIDTH-1:0]   div_hi_s, div_lo_s, quo_fix_s, rem_fix_s;

   assign in_ready    = (state_q == S_IDLE) && !flush && !rst;
   assign out_valid   = out_valid_q;
   assign result_hi   = res_hi_q;
   assign result_lo   = res_lo_q;
   assign overflow    = ovf_q;
   assign zero        = zero_q;
   assign div_by_zero = dbz_q;

   // Single-cycle ALU result and flags
   always_comb begin
      sum_s     = num1 + num2;
      diff_s    = num1 - num2;
      vamt_s    = num1[SHW-1:0];
      alu_res_s = {WIDTH{1'b0}};
      alu_ovf_s = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res_s = sum_s;
            alu_ovf_s = (num1[WIDTH-1] == num2[WIDTH-1]) && (sum_s[WIDTH-1] != num1[WIDTH-1]);
         end
         OP_ADDU: alu_res_s = sum_s;
         OP_SUB: begin
            alu_res_s = diff_s;
            alu_ovf_s = (num1[WIDTH-1] != num2[WIDTH-1]) && (diff_s[WIDTH-1] != num1[WIDTH-1]);
         end
         OP_SUBU: alu_res_s = diff_s;
         OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(num1) < $signed(num2))};
         OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (num1 < num2)};
         OP_AND:  alu_res_s = num1 & num2;
         OP_OR:   alu_res_s = num1 | num2;
         OP_XOR:  alu_res_s = num1 ^ num2;
         OP_NOR:  alu_res_s = ~(num1 | num2);
         OP_SLL:  alu_res_s = num2 << sa;
         OP_SRL:  alu_res_s = num2 >> sa;
         OP_SRA:  alu_res_s = $signed(num2) >>> sa;
         OP_SLLV: alu_res_s = num2 << vamt_s;
         OP_SRLV: alu_res_s = num2 >> vamt_s;
         OP_SRAV: alu_res_s = $signed(num2) >>> vamt_s;
         OP_LUI:  alu_res_s = {num2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
      // Undefined opcodes report all flags low, including zero.
      alu_zero_s = (op <= OP_LUI) && (alu_res_s == {WIDTH{1'b0}});
   end

   // Operand magnitudes and one shift-add / restoring-divide step
   always_comb begin
      signed_op_s = (op == OP_MULT) || (op == OP_DIV);
      neg1_s      = signed_op_s && num1[WIDTH-1];
      neg2_s      = signed_op_s && num2[WIDTH-1];
      abs1_s      = neg1_s ? ({WIDTH{1'b0}} - num1) : num1;
      abs2_s      = neg2_s ? ({WIDTH{1'b0}} - num2) : num2;

      mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
      mul_hi_s   = mul_sum_s[WIDTH:1];
      mul_lo_s   = {mul_sum_s[0], lo_q[WIDTH-1:1]};
      prod_s     = {mul_hi_s, mul_lo_s};
      prod_fix_s = neg_lo_q ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;

      div_shift_s = {hi_q, lo_q[WIDTH-1]};
      div_trial_s = div_shift_s - {1'b0, a_q};
      if (div_trial_s[WIDTH]) begin
         div_hi_s = div_shift_s[WIDTH-1:0];
         div_lo_s = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
         div_hi_s = div_trial_s[WIDTH-1:0];
         div_lo_s = {lo_q[WIDTH-2:0], 1'b1};
      end
      quo_fix_s = neg_lo_q ? ({WIDTH{1'b0}} - div_lo_s) : div_lo_s;
      rem_fix_s = neg_hi_q ? ({WIDTH{1'b0}} - div_hi_s) : div_hi_s;
   end

   // Next-state and next-register logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      neg_lo_d    = neg_lo_q;
      neg_hi_d    = neg_hi_q;
      res_hi_d    = res_hi_q;
      res_lo_d    = res_lo_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      dbz_d       = dbz_q;
      out_valid_d = out_valid_q;
      if (flush) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  cnt_d = {SHW{1'b0}};
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        a_d      = abs1_s;
                        lo_d     = abs2_s;
                        hi_d     = {WIDTH{1'b0}};
                        neg_lo_d = neg1_s ^ neg2_s;
                        neg_hi_d = 1'b0;
                        state_d  = S_MUL;
                     end
                     OP_DIV, OP_DIVU: begin
                        if (num2 == {WIDTH{1'b0}}) begin
                           res_lo_d    = {WIDTH{1'b1}};
                           res_hi_d    = num1;
                           ovf_d       = 1'b0;
                           zero_d      = 1'b0;
                           dbz_d       = 1'b1;
                           out_valid_d = 1'b1;
                           state_d     = S_DONE;
                        end else begin
                           a_d      = abs2_s;
                           lo_d     = abs1_s;
                           hi_d     = {WIDTH{1'b0}};
                           neg_lo_d = neg1_s ^ neg2_s;
                           neg_hi_d = neg1_s;
                           state_d  = S_DIV;
                        end
                     end
                     default: begin
                        res_lo_d    = alu_res_s;
                        res_hi_d    = {WIDTH{1'b0}};
                        ovf_d       = alu_ovf_s;
                        zero_d      = alu_zero_s;
                        dbz_d       = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                     end
                  endcase
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_MUL: begin
               cnt_d = cnt_q + CNT_ONE;
               hi_d  = mul_hi_s;
               lo_d  = mul_lo_s;
               if (cnt_q == CNT_LAST) begin
                  {res_hi_d, res_lo_d} = prod_fix_s;
                  ovf_d       = 1'b0;
                  zero_d      = (prod_fix_s == {(2*WIDTH){1'b0}});
                  dbz_d       = 1'b0;
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  state_d = S_MUL;
               end
            end
            S_DIV: begin
               cnt_d = cnt_q + CNT_ONE;
               hi_d  = div_hi_s;
               lo_d  = div_lo_s;
               if (cnt_q == CNT_LAST) begin
                  res_lo_d    = quo_fix_s;
                  res_hi_d    = rem_fix_s;
                  ovf_d       = 1'b0;
                  zero_d      = (quo_fix_s == {WIDTH{1'b0}}) && (rem_fix_s == {WIDTH{1'b0}});
                  dbz_d       = 1'b0;
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  state_d = S_DIV;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= {SHW{1'b0}};
         a_q         <= {WIDTH{1'b0}};
         hi_q        <= {WIDTH{1'b0}};
         lo_q        <= {WIDTH{1'b0}};
         neg_lo_q    <= 1'b0;
         neg_hi_q    <= 1'b0;
         res_hi_q    <= {WIDTH{1'b0}};
         res_lo_q    <= {WIDTH{1'b0}};
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         dbz_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         neg_lo_q    <= neg_lo_d;
         neg_hi_q    <= neg_hi_d;
         res_hi_q    <= res_hi_d;
         res_lo_q    <= res_lo_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         dbz_q       <= dbz_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Randomized and directed bench for alu_mdu_seq.
// Expected results come from a plain-arithmetic reference model and a scoreboard queue.
module tb_alu_mdu_seq;
   localparam int W  = 32;
   localparam int SW = 5;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic          overflow, zero, div_by_zero;
   logic [4:0]    op;
   logic [W-1:0]  num1, num2, result_hi, result_lo;
   logic [SW-1:0] sa;

   always #5 clk = ~clk;

   alu_mdu_seq #(.WIDTH(W), .SHW(SW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .num1(num1), .num2(num2), .sa(sa), .out_valid(out_valid),
      .out_ready(out_ready), .result_hi(result_hi), .result_lo(result_lo),
      .overflow(overflow), .zero(zero), .div_by_zero(div_by_zero)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        ovf;
      logic        zf;
      logic        dbz;
      int          lat;
      int          acc;
      bit          seen;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [31:0] last_hi, last_lo;
   logic        last_ovf, last_z, last_dbz;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // Reference model straight from the operation definitions
   function automatic exp_t model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] s);
      exp_t        e;
      longint      sa1, sb1, t;
      logic [63:0] ua, ub, p;
      logic [31:0] r;
      e   = '{hi: 32'h0, lo: 32'h0, ovf: 1'b0, zf: 1'b0, dbz: 1'b0, lat: 1, acc: 0, seen: 1'b0};
      sa1 = $signed(a);
      sb1 = $signed(b);
      ua  = {32'h0, a};
      ub  = {32'h0, b};
      r   = 32'h0;
      case (o)
         5'd0: begin t = sa1 + sb1; r = a + b; e.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         5'd1: r = a + b;
         5'd2: begin t = sa1 - sb1; r = a - b; e.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         5'd3: r = a - b;
         5'd4: r = (sa1 < sb1) ? 32'd1 : 32'd0;
         5'd5: r = (ua < ub) ? 32'd1 : 32'd0;
         5'd6: r = a & b;
         5'd7: r = a | b;
         5'd8: r = a ^ b;
         5'd9: r = ~(a | b);
         5'd10: r = b << s;
         5'd11: r = b >> s;
         5'd12: r = $signed(b) >>> s;
         5'd13: r = b << a[4:0];
         5'd14: r = b >> a[4:0];
         5'd15: r = $signed(b) >>> a[4:0];
         5'd16: r = {b[15:0], 16'h0};
         5'd17: begin p = sa1 * sb1; e.hi = p[63:32]; r = p[31:0]; e.lat = 33; end
         5'd18: begin p = ua * ub; e.hi = p[63:32]; r = p[31:0]; e.lat = 33; end
         5'd19, 5'd20: begin
            if (b == 32'h0) begin
               r = 32'hFFFF_FFFF; e.hi = a; e.dbz = 1'b1;
            end else if (o == 5'd19) begin
               t = sa1 / sb1; r = t[31:0]; t = sa1 % sb1; e.hi = t[31:0]; e.lat = 33;
            end else begin
               p = ua / ub; r = p[31:0]; p = ua % ub; e.hi = p[31:0]; e.lat = 33;
            end
         end
         default: r = 32'h0;
      endcase
      e.lo = r;
      e.zf = (o <= 5'd20) && (e.hi == 32'h0) && (e.lo == 32'h0);
      return e;
   endfunction

   // Scoreboard: acceptance, output comparison and latency on every negedge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc = cyc + 1;
         if (rst) begin
            exp_q.delete();
         end else begin
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_out_valid", 64'(out_valid), 64'(0));
               end else begin
                  chk("result_hi", 64'(result_hi), 64'(exp_q[0].hi));
                  chk("result_lo", 64'(result_lo), 64'(exp_q[0].lo));
                  chk("flags", 64'({overflow, zero, div_by_zero}),
                      64'({exp_q[0].ovf, exp_q[0].zf, exp_q[0].dbz}));
                  chk("in_ready_busy", 64'(in_ready), 64'(0));
                  if (!exp_q[0].seen) begin
                     chk("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
                     exp_q[0].seen = 1'b1;
                  end
                  if (out_ready) begin
                     last_hi  = result_hi;
                     last_lo  = result_lo;
                     last_ovf = overflow;
                     last_z   = zero;
                     last_dbz = div_by_zero;
                     void'(exp_q.pop_front());
                  end
               end
            end
            if (in_valid && in_ready) begin
               e     = model(op, num1, num2, sa);
               e.acc = cyc;
               exp_q.push_back(e);
            end
            if (flush) exp_q.delete();
         end
      end
   end

   task automatic scramble();
      in_valid = 1'b0;
      op       = 5'($urandom);
      num1     = $urandom;
      num2     = $urandom;
      sa       = 5'($urandom);
   endtask

   task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s);
      int k;
      op = o; num1 = a; num2 = b; sa = s; in_valid = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!in_ready && k < 100);
      if (!in_ready) fail_now("accept_timeout");
      @(posedge clk);
      #1;
      scramble();
   endtask

   task automatic wait_done(input bit rnd_ready);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(posedge clk);
         #1;
         k++;
      end
      if (exp_q.size() != 0) fail_now("done_timeout");
      out_ready = 1'b1;
   endtask

   task automatic run(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] s);
      issue(o, a, b, s);
      wait_done(1'b1);
   endtask

   task automatic lit(input string name, input logic [31:0] hi, input logic [31:0] lo,
                      input logic ovf, input logic zf, input logic dbz);
      chk({name, "_hi"}, 64'(last_hi), 64'(hi));
      chk({name, "_lo"}, 64'(last_lo), 64'(lo));
      chk({name, "_flags"}, 64'({last_ovf, last_z, last_dbz}), 64'({ovf, zf, dbz}));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 9))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] o;
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; op = 5'd0; num1 = 32'h0; num2 = 32'h0; sa = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_result", 64'({result_hi, result_lo}), 64'(0));
      chk("rst_flags", 64'({overflow, zero, div_by_zero}), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;

      run(5'd0, 32'h7FFF_FFFF, 32'h1, 5'd0);        lit("add_ovf", 32'h0, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
      run(5'd1, 32'h7FFF_FFFF, 32'h1, 5'd0);        lit("addu", 32'h0, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
      run(5'd17, 32'hFFFF_FFFE, 32'h3, 5'd0);       lit("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b0);
      run(5'd18, 32'hFFFF_FFFE, 32'h3, 5'd0);       lit("multu", 32'h2, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b0);
      run(5'd19, 32'hFFFF_FFF9, 32'h2, 5'd0);       lit("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
      run(5'd20, 32'h7, 32'h0, 5'd0);               lit("divu_zero", 32'h7, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
      run(5'd15, 32'h4, 32'h8000_0000, 5'd0);       lit("srav", 32'h0, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
      run(5'd4, 32'hFFFF_FFFF, 32'h1, 5'd0);        lit("slt", 32'h0, 32'h1, 1'b0, 1'b0, 1'b0);
      run(5'd5, 32'hFFFF_FFFF, 32'h1, 5'd0);        lit("sltu", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      run(5'd19, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0); lit("div_minneg", 32'h0, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
      run(5'd2, 32'h8000_0000, 32'h1, 5'd0);        lit("sub_ovf", 32'h0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
      run(5'd16, 32'h0, 32'h0000_ABCD, 5'd0);       lit("lui", 32'h0, 32'hABCD_0000, 1'b0, 1'b0, 1'b0);
      run(5'd12, 32'h0, 32'h8000_00F0, 5'd4);       lit("sra", 32'h0, 32'hF800_000F, 1'b0, 1'b0, 1'b0);
      run(5'd25, 32'h5, 32'h5, 5'd0);               lit("undef_op", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

      // Backpressure: hold out_ready low for five cycles in DONE
      out_ready = 1'b0;
      issue(5'd0, 32'h3, 32'h4, 5'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 64'(out_valid), 64'(1));
         chk("bp_in_ready", 64'(in_ready), 64'(0));
         chk("bp_result", 64'(result_lo), 64'(7));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_in_ready", 64'(in_ready), 64'(1));
      chk("bp_release_out_valid", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;

      // Flush in the tenth DIV cycle
      issue(5'd19, 32'd1000, 32'd7, 5'd0);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid), 64'(0));
      chk("flush_in_ready", 64'(in_ready), 64'(1));
      repeat (40) @(posedge clk);
      #1;
      run(5'd0, 32'h1, 32'h1, 5'd0);                lit("after_flush", 32'h0, 32'h2, 1'b0, 1'b0, 1'b0);

      // Flush together with in_valid accepts nothing
      op = 5'd0; num1 = 32'h9; num2 = 32'h9; in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready_low", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      scramble();
      flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset in the middle of a MULT
      issue(5'd17, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
      chk("rst_mid_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      run(5'd0, 32'h1, 32'h1, 5'd0);                lit("after_rst", 32'h0, 32'h2, 1'b0, 1'b0, 1'b0);

      // Randomized operations with random output backpressure
      for (int i = 0; i < 80; i++) begin
         o = ($urandom_range(0, 3) == 0) ? 5'(17 + $urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         run(o, pick(), pick(), 5'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
